// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush sequencer: merges stall requests, mul/div busy and exception redirect.
// Optional watchdog on long stalls enabled by defining PIPE_STALL_WDT_EN.
module pipe_stall_ctrl #(
   parameter int unsigned NSTAGE     = 8,
   parameter int unsigned MD_STAGE   = 4,
   parameter int unsigned CNT_W      = 6,
   parameter int unsigned REFILL_CYC = 2,
   parameter int unsigned WDT_LIMIT  = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NSTAGE-1:0] stallreq,
   input  logic              md_start,
   input  logic [CNT_W-1:0]  md_cycles,
   input  logic              excp_valid,
   input  logic [31:0]       excp_target,
   output logic [NSTAGE-1:0] stall,
   output logic              flush,
   output logic [31:0]       new_pc,
   output logic              md_busy,
   output logic              wdt_timeout
);

   localparam int unsigned RC_W    = (REFILL_CYC > 0) ? $clog2(REFILL_CYC + 1) : 1;
   localparam int unsigned RC_LAST = (REFILL_CYC > 0) ? REFILL_CYC - 1 : 0;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_FLUSH  = 2'd1,
      ST_REFILL = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              flush_q, flush_d;
   logic [31:0]       new_pc_q, new_pc_d;
   logic [CNT_W-1:0]  md_cnt_q, md_cnt_d;
   logic              md_busy_q, md_busy_d;
   logic [RC_W-1:0]   rc_cnt_q, rc_cnt_d;
   logic [NSTAGE-1:0] stall_c;

   // Stall bus: every stage at or below the highest requesting stage holds
   always_comb begin
      logic [NSTAGE-1:0] eff_req;
      logic              hit;
      eff_req = stallreq;
      hit     = 1'b0;
      stall_c = '0;
      if (md_busy_q) eff_req[MD_STAGE] = 1'b1;
      if (state_q == ST_REFILL) eff_req[0] = 1'b1;
      for (int i = int'(NSTAGE) - 1; i >= 0; i--) begin
         hit        = hit | eff_req[i];
         stall_c[i] = hit;
      end
      if (rst || state_q == ST_FLUSH) stall_c = '0;
   end

   always_comb begin
      state_d  = state_q;
      flush_d  = 1'b0;
      new_pc_d = new_pc_q;
      rc_cnt_d = rc_cnt_q;
      md_cnt_d = md_cnt_q;

      if (md_cnt_q != '0) md_cnt_d = md_cnt_q - CNT_W'(1);

      case (state_q)
         ST_RUN: begin
            if (excp_valid) begin
               state_d  = ST_FLUSH;
               flush_d  = 1'b1;
               new_pc_d = excp_target;
            end else if (md_start && !md_busy_q) begin
               md_cnt_d = md_cycles;
            end
         end
         ST_FLUSH: begin
            // Abandon any in-flight mul/div op; redirect requests are ignored here
            md_cnt_d = '0;
            rc_cnt_d = '0;
            state_d  = (REFILL_CYC > 0) ? ST_REFILL : ST_RUN;
         end
         ST_REFILL: begin
            if (excp_valid) begin
               state_d  = ST_FLUSH;
               flush_d  = 1'b1;
               new_pc_d = excp_target;
            end else if (rc_cnt_q == RC_W'(RC_LAST)) begin
               state_d = ST_RUN;
            end else begin
               rc_cnt_d = rc_cnt_q + RC_W'(1);
            end
         end
         default: state_d = ST_RUN;
      endcase

      md_busy_d = (md_cnt_d != '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_RUN;
         flush_q   <= 1'b0;
         new_pc_q  <= '0;
         md_cnt_q  <= '0;
         md_busy_q <= 1'b0;
         rc_cnt_q  <= '0;
      end else begin
         state_q   <= state_d;
         flush_q   <= flush_d;
         new_pc_q  <= new_pc_d;
         md_cnt_q  <= md_cnt_d;
         md_busy_q <= md_busy_d;
         rc_cnt_q  <= rc_cnt_d;
      end
   end

`ifdef PIPE_STALL_WDT_EN
   localparam int unsigned WDT_W = $clog2(WDT_LIMIT + 1);

   logic [WDT_W-1:0] wdt_cnt_q, wdt_cnt_d;
   logic             wdt_q, wdt_d;

   // Counts consecutive stalled cycles, parks at the limit
   always_comb begin
      wdt_cnt_d = wdt_cnt_q;
      if (flush_q || stall_c == '0) wdt_cnt_d = '0;
      else if (wdt_cnt_q != WDT_W'(WDT_LIMIT)) wdt_cnt_d = wdt_cnt_q + WDT_W'(1);
      wdt_d = wdt_q | (wdt_cnt_d == WDT_W'(WDT_LIMIT));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wdt_cnt_q <= '0;
         wdt_q     <= 1'b0;
      end else begin
         wdt_cnt_q <= wdt_cnt_d;
         wdt_q     <= wdt_d;
      end
   end

   assign wdt_timeout = wdt_q;
`else
   assign wdt_timeout = 1'b0;
`endif

   assign stall   = stall_c;
   assign flush   = flush_q;
   assign new_pc  = new_pc_q;
   assign md_busy = md_busy_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl; define PIPE_STALL_WDT_EN to exercise the watchdog.
module tb_pipe_stall_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  stallreq;
   logic        md_start;
   logic [5:0]  md_cycles;
   logic        excp_valid;
   logic [31:0] excp_target;
   logic [7:0]  stall;
   logic        flush;
   logic [31:0] new_pc;
   logic        md_busy;
   logic        wdt_timeout;

   int n_cmp = 0;
   int n_bad = 0;

   pipe_stall_ctrl #(
      .NSTAGE(8), .MD_STAGE(4), .CNT_W(6), .REFILL_CYC(2), .WDT_LIMIT(16)
   ) dut (
      .clk(clk), .rst(rst), .stallreq(stallreq), .md_start(md_start),
      .md_cycles(md_cycles), .excp_valid(excp_valid), .excp_target(excp_target),
      .stall(stall), .flush(flush), .new_pc(new_pc), .md_busy(md_busy),
      .wdt_timeout(wdt_timeout)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; stallreq = 8'hFF; md_start = 1'b0; md_cycles = '0;
      excp_valid = 1'b0; excp_target = '0;
      tick(); tick();
      n_cmp++; if (stall !== 8'h00) begin n_bad++; $display("FAIL reset_stall got %h want 00", stall); end
      n_cmp++; if (flush !== 1'b0) begin n_bad++; $display("FAIL reset_flush got %b want 0", flush); end
      n_cmp++; if (new_pc !== 32'h0) begin n_bad++; $display("FAIL reset_new_pc got %h want 0", new_pc); end
      n_cmp++; if (md_busy !== 1'b0) begin n_bad++; $display("FAIL reset_md_busy got %b want 0", md_busy); end
      n_cmp++; if (wdt_timeout !== 1'b0) begin n_bad++; $display("FAIL reset_wdt got %b want 0", wdt_timeout); end
      stallreq = 8'h00;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_stall_compose();
      logic [7:0] req [5] = '{8'h04, 8'h00, 8'h80, 8'h01, 8'h21};
      logic [7:0] exp [5] = '{8'h07, 8'h00, 8'hFF, 8'h01, 8'h3F};
      for (int i = 0; i < 5; i++) begin
         stallreq = req[i];
         #1;
         n_cmp++;
         if (stall !== exp[i]) begin
            n_bad++; $display("FAIL stall_compose[%0d] got %h want %h", i, stall, exp[i]);
         end
      end
      stallreq = 8'h00;
      tick();
   endtask

   task automatic test_md_counter();
      int busy_cyc;
      md_start = 1'b1; md_cycles = 6'd5;
      tick();
      md_start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if (md_busy !== 1'b1 || stall !== 8'h1F) begin
            n_bad++; $display("FAIL md_busy_cyc%0d got busy=%b stall=%h want 1/1f", i, md_busy, stall);
         end
         tick();
      end
      n_cmp++; if (md_busy !== 1'b0 || stall !== 8'h00) begin
         n_bad++; $display("FAIL md_done got busy=%b stall=%h want 0/00", md_busy, stall);
      end
      // zero-length op never goes busy
      md_start = 1'b1; md_cycles = 6'd0;
      tick();
      md_start = 1'b0;
      n_cmp++; if (md_busy !== 1'b0) begin n_bad++; $display("FAIL md_zero got %b want 0", md_busy); end
      // restart while busy is ignored
      md_start = 1'b1; md_cycles = 6'd3;
      tick();
      md_cycles = 6'd9;
      busy_cyc = 0;
      for (int i = 0; i < 20; i++) begin
         if (md_busy) busy_cyc++;
         tick();
         md_start = 1'b0;
      end
      n_cmp++; if (busy_cyc !== 3) begin n_bad++; $display("FAIL md_restart_busy got %0d want 3", busy_cyc); end
   endtask

   task automatic test_exception();
      excp_valid = 1'b1; excp_target = 32'hBFC0_0380;
      tick();
      excp_valid = 1'b1; excp_target = 32'h1234_5678; stallreq = 8'h10;
      #1;
      n_cmp++; if (flush !== 1'b1 || new_pc !== 32'hBFC0_0380 || stall !== 8'h00) begin
         n_bad++; $display("FAIL excp_flush got f=%b pc=%h st=%h want 1/bfc00380/00", flush, new_pc, stall);
      end
      tick();
      excp_valid = 1'b0; stallreq = 8'h00;
      #1;
      n_cmp++; if (flush !== 1'b0 || new_pc !== 32'hBFC0_0380 || stall !== 8'h01) begin
         n_bad++; $display("FAIL excp_refill1 got f=%b pc=%h st=%h want 0/bfc00380/01", flush, new_pc, stall);
      end
      tick();
      n_cmp++; if (stall !== 8'h01) begin n_bad++; $display("FAIL excp_refill2 got %h want 01", stall); end
      tick();
      n_cmp++; if (stall !== 8'h00 || flush !== 1'b0) begin
         n_bad++; $display("FAIL excp_resume got st=%h f=%b want 00/0", stall, flush);
      end
   endtask

   task automatic test_excp_during_md();
      md_start = 1'b1; md_cycles = 6'd6;
      tick();
      md_start = 1'b0;
      tick(); tick(); tick();
      excp_valid = 1'b1; excp_target = 32'h0000_1000;
      tick();
      excp_valid = 1'b0;
      n_cmp++; if (flush !== 1'b1 || md_busy !== 1'b1) begin
         n_bad++; $display("FAIL md_excp_n1 got f=%b busy=%b want 1/1", flush, md_busy);
      end
      tick();
      n_cmp++; if (md_busy !== 1'b0 || stall !== 8'h01) begin
         n_bad++; $display("FAIL md_excp_n2 got busy=%b st=%h want 0/01", md_busy, stall);
      end
      tick(); tick();
      // same-cycle md_start and exception: op dropped
      md_start = 1'b1; md_cycles = 6'd7; excp_valid = 1'b1; excp_target = 32'h0000_2000;
      tick();
      md_start = 1'b0; excp_valid = 1'b0;
      n_cmp++; if (md_busy !== 1'b0 || flush !== 1'b1) begin
         n_bad++; $display("FAIL md_excp_same_n1 got busy=%b f=%b want 0/1", md_busy, flush);
      end
      tick();
      n_cmp++; if (md_busy !== 1'b0) begin n_bad++; $display("FAIL md_excp_same_n2 got %b want 0", md_busy); end
      tick(); tick();
   endtask

   task automatic test_excp_in_refill();
      excp_valid = 1'b1; excp_target = 32'hBFC0_0380;
      tick();
      excp_valid = 1'b0;
      tick();
      excp_valid = 1'b1; excp_target = 32'h8000_0000;
      tick();
      excp_valid = 1'b0;
      n_cmp++; if (flush !== 1'b1 || new_pc !== 32'h8000_0000 || stall !== 8'h00) begin
         n_bad++; $display("FAIL refill_excp got f=%b pc=%h st=%h want 1/80000000/00", flush, new_pc, stall);
      end
      tick();
      n_cmp++; if (stall !== 8'h01) begin n_bad++; $display("FAIL refill_excp_r1 got %h want 01", stall); end
      tick();
      n_cmp++; if (stall !== 8'h01) begin n_bad++; $display("FAIL refill_excp_r2 got %h want 01", stall); end
      tick();
      n_cmp++; if (stall !== 8'h00) begin n_bad++; $display("FAIL refill_excp_run got %h want 00", stall); end
   endtask

   task automatic test_async_reset();
      md_start = 1'b1; md_cycles = 6'd9;
      tick();
      md_start = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      n_cmp++; if (md_busy !== 1'b0 || stall !== 8'h00) begin
         n_bad++; $display("FAIL async_rst got busy=%b st=%h want 0/00", md_busy, stall);
      end
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_watchdog();
      stallreq = 8'h80;
      for (int i = 0; i < 15; i++) tick();
      n_cmp++; if (wdt_timeout !== 1'b0) begin n_bad++; $display("FAIL wdt_early got %b want 0", wdt_timeout); end
      tick();
`ifdef PIPE_STALL_WDT_EN
      n_cmp++; if (wdt_timeout !== 1'b1) begin n_bad++; $display("FAIL wdt_trip got %b want 1", wdt_timeout); end
      stallreq = 8'h00;
      tick(); tick();
      n_cmp++; if (wdt_timeout !== 1'b1) begin n_bad++; $display("FAIL wdt_sticky got %b want 1", wdt_timeout); end
      rst = 1'b1;
      #1;
      n_cmp++; if (wdt_timeout !== 1'b0) begin n_bad++; $display("FAIL wdt_rst got %b want 0", wdt_timeout); end
      tick();
      rst = 1'b0;
`else
      for (int i = 0; i < 4; i++) tick();
      n_cmp++; if (wdt_timeout !== 1'b0) begin n_bad++; $display("FAIL wdt_disabled got %b want 0", wdt_timeout); end
      stallreq = 8'h00;
`endif
      tick();
   endtask

   initial begin
      test_reset();
      test_stall_compose();
      test_md_counter();
      test_exception();
      test_excp_during_md();
      test_excp_in_refill();
      test_async_reset();
      test_watchdog();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
